// File: rtl/bullet_pool.sv
// Projectile pool: NUM_BULLETS independent bullets spawned at the player
// position, each travelling horizontally in the direction the player faced
// when it was fired. The pool advances once per frame_clk edge.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// bullet_on[i]=0 | slot idle, its position follows the spawn point
// bullet_on[i]=1 | slot in flight, moves STEP per frame until it retires
// cooldown != 0  | shots blocked, counter decrements once per frame
module bullet_pool #(
    parameter int         NUM_BULLETS = 4,
    parameter logic [7:0] FIRE_KEY    = 8'd88,
    parameter logic [9:0] STEP        = 10'd8,
    parameter logic [9:0] SIZE        = 10'd4,
    parameter logic [3:0] COOLDOWN    = 4'd6,
    parameter logic [9:0] X_MIN       = 10'd0,
    parameter logic [9:0] X_MAX       = 10'd639,
    parameter logic [9:0] Y_MIN       = 10'd0,
    parameter logic [9:0] Y_MAX       = 10'd479
) (
    input  logic                        frame_clk,
    input  logic                        Reset,
    input  logic [7:0]                  keycode,
    input  logic [9:0]                  BallX,
    input  logic [9:0]                  BallY,
    input  logic [9:0]                  BallS,
    input  logic                        face_left,
    output logic [10*NUM_BULLETS-1:0]   BulletX,
    output logic [10*NUM_BULLETS-1:0]   BulletY,
    output logic [9:0]                  BulletS,
    output logic [NUM_BULLETS-1:0]      bullet_on,
    output logic                        shot_fired
);

    // Bounds are compared in 11 bits so that X + STEP + SIZE cannot wrap.
    localparam logic [10:0] X_HI = {1'b0, X_MAX};
    localparam logic [10:0] X_LO = {1'b0, X_MIN} + {1'b0, STEP} + {1'b0, SIZE};
    localparam logic [10:0] Y_HI = {1'b0, Y_MAX};
    localparam logic [10:0] Y_LO = {1'b0, Y_MIN} + {1'b0, SIZE};

    logic [NUM_BULLETS-1:0][9:0] pos_x;
    logic [NUM_BULLETS-1:0][9:0] pos_y;
    logic [NUM_BULLETS-1:0]      dir_left;
    logic [3:0]                  cooldown;

    logic [9:0]             spawn_x;
    logic                   fire_req;
    logic                   has_free;
    logic [2:0]             target;
    logic                   accept;
    logic [NUM_BULLETS-1:0] retire;

    assign BulletX = pos_x;
    assign BulletY = pos_y;
    assign BulletS = SIZE;

    // Spawn point, fire request and lowest-index idle slot selection.
    always_comb begin
        spawn_x  = face_left ? (BallX - BallS) : (BallX + BallS);
        fire_req = (keycode == FIRE_KEY);
        has_free = 1'b0;
        target   = 3'd0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!bullet_on[i]) begin
                has_free = 1'b1;
                target   = 3'(i);
            end
        end
        accept = fire_req && (cooldown == 4'd0) && has_free;
    end

    // Retire test on the current position, before this frame's move.
    always_comb begin
        logic [10:0] ahead;
        logic [10:0] y_ext;
        retire = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            ahead = {1'b0, pos_x[i]} + {1'b0, STEP} + {1'b0, SIZE};
            y_ext = {1'b0, pos_y[i]};
            retire[i] = (!dir_left[i] && (ahead > X_HI))
                     || ( dir_left[i] && ({1'b0, pos_x[i]} < X_LO))
                     || ((y_ext + {1'b0, SIZE}) > Y_HI)
                     || (y_ext < Y_LO);
        end
    end

    // Per-frame update of cooldown, shot pulse and every slot.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            pos_x      <= '0;
            pos_y      <= '0;
            dir_left   <= '0;
            bullet_on  <= '0;
            cooldown   <= 4'd0;
            shot_fired <= 1'b0;
        end else begin
            shot_fired <= accept;
            if (accept)
                cooldown <= COOLDOWN;
            else if (cooldown != 4'd0)
                cooldown <= cooldown - 4'd1;

            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (bullet_on[i]) begin
                    if (retire[i])
                        bullet_on[i] <= 1'b0;
                    else if (dir_left[i])
                        pos_x[i] <= pos_x[i] - STEP;
                    else
                        pos_x[i] <= pos_x[i] + STEP;
                end else begin
                    // Idle slots shadow the spawn point so a new shot starts there.
                    pos_x[i] <= spawn_x;
                    pos_y[i] <= BallY;
                    if (accept && (target == 3'(i))) begin
                        bullet_on[i] <= 1'b1;
                        dir_left[i]  <= face_left;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: the driver applies one frame of inputs and
// queues the hand-computed expectation; the monitor checks each frame's
// outputs against the queue on the falling edge.
module tb_bullet_pool;

    logic        frame_clk = 1'b0;
    logic        Reset     = 1'b1;
    logic [7:0]  keycode   = 8'd0;
    logic [9:0]  BallX     = 10'd0;
    logic [9:0]  BallY     = 10'd200;
    logic [9:0]  BallS     = 10'd8;
    logic        face_left = 1'b0;
    logic [39:0] BulletX;
    logic [39:0] BulletY;
    logic [9:0]  BulletS;
    logic [3:0]  bullet_on;
    logic        shot_fired;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [3:0] on;
        logic       shot;
        bit         chk_x;
        int         slot;
        logic [9:0] x;
    } exp_t;

    exp_t exp_q[$];

    bullet_pool dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .BallX      (BallX),
        .BallY      (BallY),
        .BallS      (BallS),
        .face_left  (face_left),
        .BulletX    (BulletX),
        .BulletY    (BulletY),
        .BulletS    (BulletS),
        .bullet_on  (bullet_on),
        .shot_fired (shot_fired)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every frame's outputs are compared on the falling edge.
    always @(negedge frame_clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".on"}, 32'(bullet_on), 32'(e.on));
            chk({e.name, ".shot"}, 32'(shot_fired), 32'(e.shot));
            chk({e.name, ".size"}, 32'(BulletS), 32'd4);
            if (e.chk_x)
                chk({e.name, ".x"}, 32'(BulletX[e.slot*10 +: 10]), 32'(e.x));
        end
    end

    task automatic frame(input logic [7:0] key, input logic [9:0] bx, input logic fl,
                         input string nm, input logic [3:0] on, input logic shot,
                         input bit cx, input int sl, input logic [9:0] x);
        exp_t e;
        keycode   = key;
        BallX     = bx;
        face_left = fl;
        @(posedge frame_clk);
        e.name = nm; e.on = on; e.shot = shot; e.chk_x = cx; e.slot = sl; e.x = x;
        exp_q.push_back(e);
        @(negedge frame_clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset   = 1'b1;
        keycode = 8'd0;
        BallY   = 10'd200;
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [3:0] on_e;
        logic       sh_e;
        logic [9:0] bx_e;
        logic [9:0] x_e;

        apply_reset();
        chk("reset.on", 32'(bullet_on), 32'd0);
        chk("reset.shot", 32'(shot_fired), 32'd0);

        // single shot, then rightward flight
        frame(8'd88, 10'd100, 1'b0, "single0", 4'b0001, 1'b1, 1, 0, 10'd108);
        frame(8'd0,  10'd100, 1'b0, "single1", 4'b0001, 1'b0, 1, 0, 10'd116);
        frame(8'd0,  10'd100, 1'b0, "single2", 4'b0001, 1'b0, 1, 0, 10'd124);
        frame(8'd0,  10'd100, 1'b0, "single3", 4'b0001, 1'b0, 1, 0, 10'd132);
        frame(8'd0,  10'd100, 1'b0, "single4", 4'b0001, 1'b0, 1, 0, 10'd140);
        frame(8'd0,  10'd100, 1'b0, "single5", 4'b0001, 1'b0, 1, 0, 10'd148);
        frame(8'd0,  10'd100, 1'b0, "single6", 4'b0001, 1'b0, 1, 0, 10'd156);
        frame(8'd88, 10'd100, 1'b0, "second",  4'b0011, 1'b1, 1, 1, 10'd108);

        // asynchronous reset with two slots in flight, checked between edges
        #2 Reset = 1'b1;
        #1;
        chk("async_rst.on", 32'(bullet_on), 32'd0);
        chk("async_rst.shot", 32'(shot_fired), 32'd0);
        chk("async_rst.x", 32'(BulletX[31:0]), 32'd0);
        chk("async_rst.y", 32'(BulletY[31:0]), 32'd0);
        apply_reset();

        // held key: auto-fire at the cooldown rate
        for (int k = 1; k <= 20; k++) begin
            sh_e = (k == 1) || (k == 8) || (k == 15);
            on_e = (k < 8) ? 4'b0001 : (k < 15) ? 4'b0011 : 4'b0111;
            x_e  = 10'(108 + 8 * (k - 1));
            frame(8'd88, 10'd100, 1'b0, $sformatf("hold%0d", k), on_e, sh_e, 1, 0, x_e);
        end
        apply_reset();

        // full pool; slot0 retires at the right edge and is reused a frame later
        for (int k = 1; k <= 32; k++) begin
            bx_e = (k == 1) ? 10'd388 : 10'd100;
            sh_e = (k == 1) || (k == 8) || (k == 15) || (k == 22) || (k == 32);
            if (k < 8)       on_e = 4'b0001;
            else if (k < 15) on_e = 4'b0011;
            else if (k < 22) on_e = 4'b0111;
            else if (k < 31) on_e = 4'b1111;
            else if (k == 31) on_e = 4'b1110;
            else             on_e = 4'b1111;
            if (k <= 30)      x_e = 10'(396 + 8 * (k - 1));
            else if (k == 31) x_e = 10'd628;
            else              x_e = 10'd108;
            frame(8'd88, bx_e, 1'b0, $sformatf("full%0d", k), on_e, sh_e, 1, 0, x_e);
        end
        apply_reset();

        // leftward flight to the left edge, then idle tracking
        frame(8'd88, 10'd40, 1'b1, "left0",   4'b0001, 1'b1, 1, 0, 10'd32);
        frame(8'd0,  10'd40, 1'b1, "left1",   4'b0001, 1'b0, 1, 0, 10'd24);
        frame(8'd0,  10'd40, 1'b1, "left2",   4'b0001, 1'b0, 1, 0, 10'd16);
        frame(8'd0,  10'd40, 1'b1, "left3",   4'b0001, 1'b0, 1, 0, 10'd8);
        frame(8'd0,  10'd40, 1'b1, "left_ret",4'b0000, 1'b0, 1, 0, 10'd8);
        frame(8'd0,  10'd40, 1'b1, "track0",  4'b0000, 1'b0, 1, 0, 10'd32);
        frame(8'd0,  10'd50, 1'b1, "track1",  4'b0000, 1'b0, 1, 0, 10'd42);
        frame(8'd0,  10'd50, 1'b0, "track2",  4'b0000, 1'b0, 1, 1, 10'd58);

        // spawn at an out-of-bounds Y retires on the following frame
        BallY = 10'd2;
        frame(8'd88, 10'd100, 1'b0, "oob_spawn", 4'b0001, 1'b1, 1, 0, 10'd108);
        frame(8'd0,  10'd100, 1'b0, "oob_ret",   4'b0000, 1'b0, 1, 0, 10'd108);

        @(negedge frame_clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
